// File: rtl/dac_words_to_volts.sv
// DAC word to signed volts (100 uV units) readback using two-point calibration.
// One request in flight; one restoring divide step per cycle.
module dac_words_to_volts #(
    parameter int DAC_TWOPOINTFIVE = 157,
    parameter int DAC_ZERO         = 2077,
    parameter int N                = 16,
    parameter int M                = 12,
    parameter int DIV_W            = M + 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [M-1:0]        in_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_volts,
    output logic                out_sat
);

    localparam int CNT_W     = $clog2(DIV_W);
    localparam int DEN       = DAC_TWOPOINTFIVE - DAC_ZERO;
    localparam int DEN_ABS_I = (DEN < 0) ? -DEN : DEN;

    localparam logic signed [DIV_W:0] SCALE   = (DIV_W+1)'(25000);
    localparam logic signed [DIV_W:0] ZERO_S  = (DIV_W+1)'(DAC_ZERO);
    localparam logic [DIV_W:0]        DEN_ABS = (DIV_W+1)'(DEN_ABS_I);
    localparam logic [DIV_W-1:0]      HALF    = DIV_W'(DEN_ABS_I / 2);
    localparam logic                  DEN_NEG = (DEN < 0);
    localparam logic [DIV_W-1:0]      POS_MAX = DIV_W'((64'd1 << (N-1)) - 64'd1);
    localparam logic [DIV_W-1:0]      NEG_MAG = DIV_W'(64'd1 << (N-1));
    localparam logic [N-1:0]          OUT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]          OUT_MIN = {1'b1, {(N-1){1'b0}}};

    generate
        if (DAC_TWOPOINTFIVE == DAC_ZERO) begin : g_bad_cal
            $error("dac_words_to_volts: calibration points must differ");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

    state_t             state, state_nx;
    logic [M-1:0]       word;
    logic [DIV_W-1:0]   dividend;
    logic [DIV_W-1:0]   rem;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic signed [DIV_W:0] diff, num;
    logic [DIV_W-1:0]      num_abs;
    logic [DIV_W:0]        rem_sh;
    logic                  step_ge;
    logic                  res_sat;
    logic [N-1:0]          res;

    always_comb begin
        diff    = $signed({{(DIV_W+1-M){1'b0}}, word}) - ZERO_S;
        num     = diff * SCALE;
        num_abs = DIV_W'(num[DIV_W] ? -num : num);
        rem_sh  = {rem, dividend[DIV_W-1]};
        step_ge = (rem_sh >= DEN_ABS);
        // dividend holds the quotient once all steps have shifted through
        res_sat = neg ? (dividend > NEG_MAG) : (dividend > POS_MAX);
        if (res_sat)  res = neg ? OUT_MIN : OUT_MAX;
        else if (neg) res = -dividend[N-1:0];
        else          res = dividend[N-1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid && in_ready)     state_nx = PREP;
            PREP:                                  state_nx = DIV;
            DIV:     if (cnt == CNT_W'(DIV_W - 1)) state_nx = DONE;
            DONE:    if (out_valid && out_ready)   state_nx = IDLE;
            default:                               state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            word      <= '0;
            dividend  <= '0;
            rem       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            out_volts <= '0;
            out_sat   <= 1'b0;
        end else begin
            in_ready <= (state_nx == IDLE);
            case (state)
                IDLE: if (in_valid && in_ready) word <= in_word;
                PREP: begin
                    dividend <= num_abs + HALF;
                    rem      <= '0;
                    cnt      <= '0;
                    neg      <= (num[DIV_W] ^ DEN_NEG) && (num != '0);
                end
                DIV: begin
                    rem      <= step_ge ? DIV_W'(rem_sh - DEN_ABS) : DIV_W'(rem_sh);
                    dividend <= {dividend[DIV_W-2:0], step_ge};
                    cnt      <= cnt + 1'b1;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_volts <= res;
                        out_sat   <= res_sat;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_words_to_volts.sv
// Randomized self-checking bench for dac_words_to_volts; default and N=12 instances
// share one request stream and are compared against a plain-arithmetic model.
module tb_dac_words_to_volts;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_word = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_sat;
    logic signed [15:0] out_volts;
    logic        in_ready12, out_valid12, out_sat12;
    logic signed [11:0] out_volts12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dac_words_to_volts u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_volts(out_volts), .out_sat(out_sat)
    );

    dac_words_to_volts #(.N(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12),
        .in_word(in_word), .out_valid(out_valid12), .out_ready(out_ready),
        .out_volts(out_volts12), .out_sat(out_sat12)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: calibration inverse with round-half-away-from-zero and clamp to n bits.
    function automatic void model(input int w, input int n, output longint v, output longint s);
        longint num, den, q, lo, hi;
        num = longint'(w - 2077) * 25000;
        den = 157 - 2077;
        q   = ((num < 0 ? -num : num) + (den < 0 ? -den : den) / 2) / (den < 0 ? -den : den);
        v   = (((num < 0) != (den < 0)) && num != 0) ? -q : q;
        hi  = (longint'(1) << (n - 1)) - 1;
        lo  = -(longint'(1) << (n - 1));
        s   = 0;
        if (v > hi) begin v = hi; s = 1; end
        if (v < lo) begin v = lo; s = 1; end
    endfunction

    task automatic run_req(input int w, input int hold);
        int lat, tmo;
        longint ev, es, ev12, es12;
        tmo = 0;
        while (!in_ready && tmo < 100) begin @(negedge clk); tmo++; end
        chk("ready_wait", longint'(in_ready), 1);
        in_valid = 1'b1;
        in_word  = 12'(w);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = 12'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk("latency", lat, 30);
        model(w, 16, ev, es);
        model(w, 12, ev12, es12);
        chk($sformatf("volts w=%0d", w), longint'(out_volts), ev);
        chk($sformatf("sat w=%0d", w), longint'(out_sat), es);
        chk($sformatf("volts12 w=%0d", w), longint'(out_volts12), ev12);
        chk($sformatf("sat12 w=%0d", w), longint'(out_sat12), es12);
        chk("ready_in_done", longint'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_word  = 12'($urandom);
            @(negedge clk);
            chk("bp_valid", longint'(out_valid), 1);
            chk("bp_ready", longint'(in_ready), 0);
            chk("bp_volts", longint'(out_volts), ev);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", longint'(out_valid), 0);
        chk("post_ready", longint'(in_ready), 1);
        chk("post_hold", longint'(out_volts), ev);
    endtask

    initial begin
        int dir[] = '{2077, 157, 0, 4095, 2053, 2101, 2076};
        #12;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_ready", longint'(in_ready), 0);
        chk("rst_volts", longint'(out_volts), 0);
        chk("rst_sat", longint'(out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_ready0", longint'(in_ready), 0);
        @(negedge clk);
        chk("rel_ready1", longint'(in_ready), 1);

        foreach (dir[i]) run_req(dir[i], 0);
        run_req(2000, 20);
        for (int i = 0; i < 40; i++) run_req(int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)));

        // abort mid-divide: previous result is nonzero, reset must clear it at once
        run_req(4095, 0);
        in_valid = 1'b1;
        in_word  = 12'd157;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", longint'(out_valid), 0);
        chk("abort_volts", longint'(out_volts), 0);
        chk("abort_sat", longint'(out_sat), 0);
        chk("abort_ready", longint'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(2069, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
